loader_mem_arbiter: RTL and testbench
=====================================

// Module: loader_mem_arbiter
// PURPOSE
// Sits downstream of the APF data loader, in the clk_memory domain.
// Buffers loader byte/word writes and arbitrates them into one single-port sync RAM that the core also reads.
// Core reads always win; loader writes drain in idle cycles.
// Tracks download lifecycle (drain, done pulse), write count and error flags for the core reset/boot logic.
// PARAMETERS
// LOADER_ADDR_WIDTH  28    width of incoming loader address
// MEM_ADDR_WIDTH     13    RAM address width
// DATA_WIDTH         8     loader/RAM data width (8 or 16)
// MEM_DEPTH          8192  valid words; loader addr >= MEM_DEPTH is out of range
// FIFO_DEPTH         4     write buffer entries (power of 2, >=2)
// PORTS
// clk_memory        in   1                  memory clock, all logic rising-edge
// reset             in   1                  synchronous, active-high
// loader_active     in   1                  high while APF download in progress
// loader_wr_en      in   1                  1-cycle write strobe from data loader
// loader_wr_addr    in   LOADER_ADDR_WIDTH  write address
// loader_wr_data    in   DATA_WIDTH         write data
// core_rd_en        in   1                  core read request, sampled every cycle
// core_rd_addr      in   MEM_ADDR_WIDTH     core read address
// core_rd_data      out  DATA_WIDTH         read data (= mem_rd_data)
// core_rd_valid     out  1                  core_rd_data valid; 1 cycle after core_rd_en
// mem_addr          out  MEM_ADDR_WIDTH     RAM address (combinational mux)
// mem_wr_en         out  1                  RAM write enable (combinational)
// mem_wr_data       out  DATA_WIDTH         RAM write data
// mem_rd_data       in   DATA_WIDTH         RAM q, 1-cycle read latency
// busy              out  1                  FIFO non-empty or state != IDLE/DONE
// load_done         out  1                  1-cycle pulse when download fully committed
// words_written     out  MEM_ADDR_WIDTH+1   RAM writes committed since load start, saturating
// range_error       out  1                  sticky: out-of-range write dropped
// overflow_error    out  1                  sticky: write dropped, FIFO full
// BEHAVIOUR
// - Reset: all outputs 0, FIFO empty, state IDLE, counters/flags cleared.
// - Accept: loader_wr_en with addr < MEM_DEPTH and FIFO not full -> pushed same edge (truncated to MEM_ADDR_WIDTH).
//   addr >= MEM_DEPTH -> dropped, range_error<=1. FIFO full -> dropped, overflow_error<=1.
// - Arbitration, per cycle:
//   - If core_rd_en: mem_addr=core_rd_addr, mem_wr_en=0, FIFO not popped.
//   - Else if FIFO non-empty: mem_addr/mem_wr_data = FIFO head, mem_wr_en=1, pop at edge, words_written+1 (saturate).
//   - Else mem_wr_en=0, mem_addr=0.
// - Simultaneous push and pop on a full FIFO: both happen and the write is accepted (pop frees the slot).
// - Push on empty FIFO: head is visible next cycle, so minimum accept-to-RAM latency is 1 cycle.
// - core_rd_valid is registered core_rd_en; core_rd_data passes mem_rd_data through.
// - FSM (next state at edge):
//   - IDLE: loader_active rise -> LOADING; clear words_written, range_error, overflow_error.
//   - LOADING: loader_active fall -> DRAIN.
//   - DRAIN: FIFO empty and no push this cycle -> DONE with load_done=1 for that one cycle.
//     loader_active re-rise -> LOADING without clearing.
//   - DONE: next cycle -> IDLE.
// - Writes arriving in IDLE are still committed and counted.
// - Errors stay set until the next load start or reset.
// - Reset mid-load: FIFO flushed and uncommitted writes lost; reset dominates every other input.
// - A FIFO-full condition occurs only under sustained core reads; loader spacing is at least 4 cycles.
// STRUCTURE
// - loader_pkg: state enum typedef (IDLE, LOADING, DRAIN, DONE) and the FIFO entry struct {addr, data}.
// - Sub-module sync_fifo (single clock, params WIDTH/DEPTH, push/pop/full/empty, sync reset).
// - This module holds the accept logic, arbitration mux, FSM and counters.
// TESTING
// - Reset, then 4 writes addr 0..3 data A0..A3, no core reads.
//   -> RAM words 0..3 = A0..A3; words_written=4; each write committed 1 cycle after its strobe.
// - core_rd_en held 10 cycles while 4 writes arrive.
//   -> mem_wr_en=0 throughout; FIFO full; a 5th write sets overflow_error.
//   -> After release, 4 commits on 4 consecutive cycles.
// - Write to addr 8192 (MEM_DEPTH) -> no RAM write; range_error=1; words_written unchanged.
// - loader_active 1->0 with 2 entries queued and core reads blocking.
//   -> load_done pulses exactly once, the cycle the last entry commits; busy=0 after.
// - Second load start -> words_written, range_error, overflow_error cleared the cycle after loader_active rises.
// - reset asserted with 3 entries queued -> no further mem_wr_en; all outputs 0 next cycle.

Source files
------------

// File: rtl/loader_mem_arbiter_pkg.sv
// Shared types and default widths for the loader write buffer / RAM arbiter.
package loader_mem_arbiter_pkg;

  localparam int DEF_LOADER_ADDR_WIDTH = 28;
  localparam int DEF_MEM_ADDR_WIDTH    = 13;
  localparam int DEF_DATA_WIDTH        = 8;

  // Download lifecycle as seen by the core reset/boot logic.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOADING,
    ST_DRAIN,
    ST_DONE
  } load_state_e;

endpackage

// File: rtl/loader_mem_arbiter_if.sv
// Bundle of loader write port, core read port, RAM port and status outputs.
interface loader_mem_arbiter_if
  import loader_mem_arbiter_pkg::*;
#(
  parameter int LOADER_ADDR_WIDTH = DEF_LOADER_ADDR_WIDTH,
  parameter int MEM_ADDR_WIDTH    = DEF_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH
);
  logic                         loader_active;
  logic                         loader_wr_en;
  logic [LOADER_ADDR_WIDTH-1:0] loader_wr_addr;
  logic [DATA_WIDTH-1:0]        loader_wr_data;
  logic                         core_rd_en;
  logic [MEM_ADDR_WIDTH-1:0]    core_rd_addr;
  logic [DATA_WIDTH-1:0]        core_rd_data;
  logic                         core_rd_valid;
  logic [MEM_ADDR_WIDTH-1:0]    mem_addr;
  logic                         mem_wr_en;
  logic [DATA_WIDTH-1:0]        mem_wr_data;
  logic [DATA_WIDTH-1:0]        mem_rd_data;
  logic                         busy;
  logic                         load_done;
  logic [MEM_ADDR_WIDTH:0]      words_written;
  logic                         range_error;
  logic                         overflow_error;

  modport slave (
    input  loader_active, loader_wr_en, loader_wr_addr, loader_wr_data,
    input  core_rd_en, core_rd_addr, mem_rd_data,
    output core_rd_data, core_rd_valid, mem_addr, mem_wr_en, mem_wr_data,
    output busy, load_done, words_written, range_error, overflow_error
  );

  modport master (
    output loader_active, loader_wr_en, loader_wr_addr, loader_wr_data,
    output core_rd_en, core_rd_addr, mem_rd_data,
    input  core_rd_data, core_rd_valid, mem_addr, mem_wr_en, mem_wr_data,
    input  busy, load_done, words_written, range_error, overflow_error
  );
endinterface

// File: rtl/loader_mem_arbiter_sync_fifo.sv
// Single-clock FIFO with registered occupancy; head is read combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             last
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // NOTE: storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign last    = (count == (PTR_W+1)'(1));
endmodule

// File: rtl/loader_mem_arbiter.sv
// Buffers APF loader writes and drains them into a single-port RAM in cycles
// the core is not reading; tracks download lifecycle, write count and errors.
module loader_mem_arbiter
  import loader_mem_arbiter_pkg::*;
#(
  parameter int LOADER_ADDR_WIDTH = DEF_LOADER_ADDR_WIDTH,
  parameter int MEM_ADDR_WIDTH    = DEF_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH         = 8192,
  parameter int FIFO_DEPTH        = 4
) (
  input logic               clk_memory,
  input logic               reset,
  loader_mem_arbiter_if.slave bus
);
  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     data;
  } wr_entry_t;

  localparam int ENTRY_WIDTH = $bits(wr_entry_t);
  localparam logic [LOADER_ADDR_WIDTH-1:0] ADDR_LIMIT = LOADER_ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [MEM_ADDR_WIDTH:0]      WORDS_MAX  = '1;

  load_state_e state;
  logic        active_q;
  logic        in_range;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_last;
  logic        active_rise;
  logic        active_fall;
  logic        drain_complete;
  wr_entry_t   push_entry;
  wr_entry_t   head;

  assign in_range    = (bus.loader_wr_addr < ADDR_LIMIT);
  assign active_rise = bus.loader_active && !active_q;
  assign active_fall = !bus.loader_active && active_q;

  // Core reads always win the RAM port; reset blocks both sides of the FIFO.
  assign pop  = !reset && !bus.core_rd_en && !fifo_empty;
  assign push = !reset && bus.loader_wr_en && in_range && (!fifo_full || pop);

  assign push_entry = '{addr: bus.loader_wr_addr[MEM_ADDR_WIDTH-1:0],
                        data: bus.loader_wr_data};

  // Download is committed once the FIFO is empty after this edge with nothing new arriving.
  assign drain_complete = !push && (fifo_empty || (pop && fifo_last));

  sync_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_memory),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (push_entry),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .last    (fifo_last)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    bus.mem_wr_en   = pop;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    if (!reset && bus.core_rd_en) begin
      bus.mem_addr = bus.core_rd_addr;
    end else if (pop) begin
      bus.mem_addr    = head.addr;
      bus.mem_wr_data = head.data;
    end
  end

  assign bus.core_rd_data = bus.mem_rd_data;
  assign bus.busy = !fifo_empty || (state == ST_LOADING) || (state == ST_DRAIN);

  always_ff @(posedge clk_memory) begin
    if (reset) begin
      state              <= ST_IDLE;
      active_q           <= 1'b0;
      bus.core_rd_valid  <= 1'b0;
      bus.load_done      <= 1'b0;
      bus.words_written  <= '0;
      bus.range_error    <= 1'b0;
      bus.overflow_error <= 1'b0;
    end else begin
      active_q          <= bus.loader_active;
      bus.core_rd_valid <= bus.core_rd_en;
      bus.load_done     <= 1'b0;

      if (pop && (bus.words_written != WORDS_MAX))
        bus.words_written <= bus.words_written + 1'b1;
      if (bus.loader_wr_en && !in_range)
        bus.range_error <= 1'b1;
      if (bus.loader_wr_en && in_range && fifo_full && !pop)
        bus.overflow_error <= 1'b1;

      // Load-start clears are placed last so they override same-cycle updates.
      case (state)
        ST_IDLE: begin
          if (active_rise) begin
            state              <= ST_LOADING;
            bus.words_written  <= '0;
            bus.range_error    <= 1'b0;
            bus.overflow_error <= 1'b0;
          end
        end
        ST_LOADING: begin
          if (active_fall) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (active_rise) begin
            state <= ST_LOADING;
          end else if (drain_complete) begin
            state         <= ST_DONE;
            bus.load_done <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_loader_mem_arbiter.sv
// Randomized + directed scoreboard bench for loader_mem_arbiter with a queue-based reference model.
module tb_loader_mem_arbiter;
  localparam int AW    = 28;
  localparam int MW    = 13;
  localparam int DW    = 8;
  localparam int DEPTH = 8192;
  localparam int FD    = 4;
  localparam int WMAX  = 16383;

  typedef struct packed {
    logic [MW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk_memory = 1'b0;
  logic reset      = 1'b1;
  always #5 clk_memory = ~clk_memory;

  loader_mem_arbiter_if #(.LOADER_ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MW), .DATA_WIDTH(DW)) bus();

  loader_mem_arbiter #(
    .LOADER_ADDR_WIDTH (AW),
    .MEM_ADDR_WIDTH    (MW),
    .DATA_WIDTH        (DW),
    .MEM_DEPTH         (DEPTH),
    .FIFO_DEPTH        (FD)
  ) dut (
    .clk_memory (clk_memory),
    .reset      (reset),
    .bus        (bus)
  );

  // Behavioural single-port RAM with 1-cycle read latency.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk_memory) begin
    if (bus.mem_wr_en) ram[bus.mem_addr] <= bus.mem_wr_data;
    bus.mem_rd_data <= ram[bus.mem_addr];
  end

  // Reference model state
  exp_t          exp_q[$];
  int            occ;
  int            m_words;
  bit            m_range;
  bit            m_ovf;
  bit            prev_act;
  bit            exp_pop;
  logic [DW-1:0] shadow [int];

  int  total;
  int  bad;
  int  cyc;
  int  last_commit_cyc;
  int  done_cyc;
  int  done_cnt;
  bit  mon_on;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Apply one cycle of stimulus and advance the model across the coming edge.
  task automatic step(input bit rd, input int ra, input bit we, input int wa,
                      input int wd, input bit act, input bit rst);
    bit acc;
    acc = 1'b0;
    bus.core_rd_en     = rd;
    bus.core_rd_addr   = MW'(ra);
    bus.loader_wr_en   = we;
    bus.loader_wr_addr = AW'(wa);
    bus.loader_wr_data = DW'(wd);
    bus.loader_active  = act;
    reset              = rst;
    exp_pop = !rst && !rd && (occ > 0);
    if (rst) begin
      exp_q.delete();
      occ = 0; m_words = 0; m_range = 0; m_ovf = 0; prev_act = 0;
    end else begin
      if (act && !prev_act) begin
        m_words = 0; m_range = 0; m_ovf = 0;
      end
      if (exp_pop && m_words < WMAX) m_words++;
      if (we) begin
        if (wa >= DEPTH) m_range = 1;
        else if (occ < FD || exp_pop) begin
          exp_q.push_back('{addr: MW'(wa), data: DW'(wd)});
          acc = 1'b1;
        end else m_ovf = 1;
      end
      occ = occ + int'(acc) - int'(exp_pop);
      prev_act = act;
    end
    @(posedge clk_memory);
    #1;
  endtask

  task automatic idle(input int n, input bit act);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, act, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},          32'(bus.busy), 0);
    check({tag, ".load_done"},     32'(bus.load_done), 0);
    check({tag, ".words_written"}, 32'(bus.words_written), 0);
    check({tag, ".range_error"},   32'(bus.range_error), 0);
    check({tag, ".overflow"},      32'(bus.overflow_error), 0);
    check({tag, ".mem_wr_en"},     32'(bus.mem_wr_en), 0);
    check({tag, ".mem_addr"},      32'(bus.mem_addr), 0);
    check({tag, ".mem_wr_data"},   32'(bus.mem_wr_data), 0);
    check({tag, ".core_rd_valid"}, 32'(bus.core_rd_valid), 0);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".words_written"}, 32'(bus.words_written), 32'(m_words));
    check({tag, ".range_error"},   32'(bus.range_error), 32'(m_range));
    check({tag, ".overflow"},      32'(bus.overflow_error), 32'(m_ovf));
  endtask

  initial forever begin
    @(posedge clk_memory);
    cyc++;
  end

  // Monitor: compares RAM writes and core reads against the model as they appear.
  initial begin
    exp_t          e;
    bit            rd_pend;
    bit            rd_known;
    logic [DW-1:0] rd_exp;
    rd_pend  = 0;
    rd_known = 0;
    rd_exp   = '0;
    forever begin
      @(negedge clk_memory);
      if (mon_on) begin
        check("mem_wr_en", 32'(bus.mem_wr_en), 32'(exp_pop));
        if (bus.core_rd_en && !reset)
          check("mem_addr_rd", 32'(bus.mem_addr), 32'(bus.core_rd_addr));
        if (bus.mem_wr_en) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr=%0h with no pending entry (cycle %0d)",
                     bus.mem_addr, cyc);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
            check("wr_data", 32'(bus.mem_wr_data), 32'(e.data));
            shadow[int'(e.addr)] = e.data;
            last_commit_cyc = cyc;
          end
        end
        check("rd_valid", 32'(bus.core_rd_valid), 32'(rd_pend));
        if (bus.core_rd_valid && rd_known)
          check("rd_data", 32'(bus.core_rd_data), 32'(rd_exp));
        rd_pend  = bus.core_rd_en && !reset;
        rd_known = rd_pend && shadow.exists(int'(bus.core_rd_addr));
        if (rd_known) rd_exp = shadow[int'(bus.core_rd_addr)];
        if (bus.load_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bus.core_rd_en = 0; bus.core_rd_addr = '0; bus.loader_wr_en = 0;
    bus.loader_wr_addr = '0; bus.loader_wr_data = '0; bus.loader_active = 0;
    mon_on = 0;

    // Reset state
    repeat (3) step(0, 0, 0, 0, 0, 0, 1);
    check_all_zero("reset");
    mon_on = 1;

    // Load start, then 4 spaced writes with no reads
    step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, i, 'hA0 + i, 1, 0);
      idle(3, 1);
    end
    check("basic.words_written", 32'(bus.words_written), 4);
    for (int i = 0; i < 4; i++) check("basic.ram", 32'(ram[i]), 32'('hA0 + i));

    // Sustained reads while writes arrive: FIFO fills, 5th write overflows
    for (int i = 0; i < 10; i++)
      step(1, $urandom_range(0, 3), (i % 2 == 0), 16 + i, $urandom_range(0, 255), 1, 0);
    check("block.overflow", 32'(bus.overflow_error), 1);
    check_model("block");
    idle(6, 1);
    check("block.words_written", 32'(bus.words_written), 8);

    // Out-of-range write is dropped
    step(0, 0, 1, DEPTH, 'h55, 1, 0);
    idle(3, 1);
    check("range.error", 32'(bus.range_error), 1);
    check("range.words_written", 32'(bus.words_written), 8);

    // Drain with 2 queued entries behind core reads
    done_cnt = 0;
    step(1, 1, 1, 10, 'h11, 1, 0);
    step(1, 2, 0, 0, 0, 1, 0);
    step(1, 3, 1, 11, 'h22, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 10, 0, 0, 0, 0, 0);
    step(1, 11, 0, 0, 0, 0, 0);
    idle(6, 0);
    check("drain.done_count", 32'(done_cnt), 1);
    check("drain.done_cycle", 32'(done_cyc), 32'(last_commit_cyc + 1));
    check("drain.busy", 32'(bus.busy), 0);
    check("drain.words_written", 32'(bus.words_written), 10);

    // Second load start clears count and sticky errors
    step(0, 0, 0, 0, 0, 1, 0);
    check("restart.words_written", 32'(bus.words_written), 0);
    check("restart.range_error", 32'(bus.range_error), 0);
    check("restart.overflow", 32'(bus.overflow_error), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit rd;
      bit we;
      int wa;
      rd = ($urandom_range(0, 99) < 45);
      we = ($urandom_range(0, 3) == 0);
      wa = ($urandom_range(0, 9) == 0) ? DEPTH + int'($urandom_range(0, 1000))
                                       : int'($urandom_range(0, 31));
      step(rd, $urandom_range(0, 31), we, wa, $urandom_range(0, 255), 1, 0);
    end
    idle(8, 1);
    check_model("random");
    check("random.queue_empty", 32'(exp_q.size()), 0);

    // Reset with 3 entries queued
    step(1, 0, 1, 40, 'h40, 1, 0);
    step(1, 1, 1, 41, 'h41, 1, 0);
    step(1, 2, 1, 42, 'h42, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    check_all_zero("midreset");
    idle(4, 0);
    check("midreset.busy_after", 32'(bus.busy), 0);
    check("midreset.words_after", 32'(bus.words_written), 0);

    mon_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
